// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states, access
// sizes and the opcode decoder used at issue time.
package lsu_pkg;

  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LD  = 6'd48;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STD = 6'd52;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WB} lsu_state_e;

  // Access size as log2 of the byte count (1/2/4/8 bytes)
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} lsu_size_e;

  typedef struct packed {
    logic      valid;
    logic      is_load;
    logic      sign_ext;
    lsu_size_e size;
  } lsu_op_t;

  function automatic lsu_op_t decode_op(input logic [5:0] op);
    lsu_op_t d;
    d = '{valid: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SZ_BYTE};
    case (op)
      OP_LBZ: d.size = SZ_BYTE;
      OP_LHZ: d.size = SZ_HALF;
      OP_LHA: begin d.size = SZ_HALF; d.sign_ext = 1'b1; end
      OP_LWZ: d.size = SZ_WORD;
      OP_LD:  d.size = SZ_DWORD;
      OP_STB: begin d.size = SZ_BYTE;  d.is_load = 1'b0; end
      OP_STH: begin d.size = SZ_HALF;  d.is_load = 1'b0; end
      OP_STW: begin d.size = SZ_WORD;  d.is_load = 1'b0; end
      OP_STD: begin d.size = SZ_DWORD; d.is_load = 1'b0; end
      default: begin d.valid = 1'b0; d.is_load = 1'b0; end
    endcase
    return d;
  endfunction

  function automatic logic [2:0] size_low_mask(input lsu_size_e s);
    case (s)
      SZ_BYTE:  return 3'd0;
      SZ_HALF:  return 3'd1;
      SZ_WORD:  return 3'd3;
      default:  return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store placement into 64-bit
// lanes, plus load extraction with zero/sign extension.
module lsu_align (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [2:0]  offset,
  input  logic [63:0] store_data,
  input  logic [63:0] load_raw,
  output logic [7:0]  byte_en,
  output logic [63:0] store_lanes,
  output logic [63:0] load_value
);
  import lsu_pkg::*;

  logic [7:0]  size_be;
  logic [63:0] size_bits;
  logic [5:0]  bit_shift;
  logic [63:0] extracted;

  always_comb begin
    bit_shift = {offset, 3'b000};
    case (lsu_size_e'(size))
      SZ_BYTE: begin size_be = 8'h01; size_bits = 64'h0000_0000_0000_00FF; end
      SZ_HALF: begin size_be = 8'h03; size_bits = 64'h0000_0000_0000_FFFF; end
      SZ_WORD: begin size_be = 8'h0F; size_bits = 64'h0000_0000_FFFF_FFFF; end
      default: begin size_be = 8'hFF; size_bits = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase

    byte_en     = size_be << offset;
    store_lanes = (store_data & size_bits) << bit_shift;

    extracted = load_raw >> bit_shift;
    case (lsu_size_e'(size))
      SZ_BYTE: load_value = {{56{sign_ext & extracted[7]}},  extracted[7:0]};
      SZ_HALF: load_value = {{48{sign_ext & extracted[15]}}, extracted[15:0]};
      SZ_WORD: load_value = {{32{sign_ext & extracted[31]}}, extracted[31:0]};
      default: load_value = extracted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: computes the D-form effective address, runs one memory
// transaction and returns extended load data toward the register file.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        ra_is_zero,
  input  logic [63:0] ra_data,
  input  logic [63:0] rs_data,
  input  logic [15:0] disp,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [5:0]  wb_opcode,
  output logic [63:0] wb_data,
  output logic        done,
  output logic        align_err,
  output logic        bus_err
);
  import lsu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state_q, state_d;
  lsu_size_e        size_q, size_d;
  logic             sign_q, sign_d, is_load_q, is_load_d;
  logic [2:0]       off_q, off_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             req_valid_q, req_valid_d, we_q, we_d;
  logic [63:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]       be_q, be_d;
  logic             wb_valid_q, wb_valid_d, done_q, done_d;
  logic             align_err_q, align_err_d, bus_err_q, bus_err_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [5:0]       wb_opcode_q, wb_opcode_d;
  logic [63:0]      wb_data_q, wb_data_d;

  lsu_op_t     op_now;
  logic [63:0] ea_now;
  logic        misaligned;
  logic        in_idle;
  logic [7:0]  al_be;
  logic [63:0] al_store, al_load;

  always_comb begin
    op_now     = decode_op(opcode);
    ea_now     = (ra_is_zero ? 64'd0 : ra_data) + {{48{disp[15]}}, disp};
    misaligned = (ea_now[2:0] & size_low_mask(op_now.size)) != 3'd0;
    in_idle    = (state_q == ST_IDLE);
  end

  // Placement uses the incoming access in IDLE; extraction uses the latched one
  lsu_align u_align (
    .size        (in_idle ? op_now.size : size_q),
    .sign_ext    (sign_q),
    .offset      (in_idle ? ea_now[2:0] : off_q),
    .store_data  (rs_data),
    .load_raw    (mem_rdata),
    .byte_en     (al_be),
    .store_lanes (al_store),
    .load_value  (al_load)
  );

  always_comb begin
    state_d = state_q;  size_d = size_q;  sign_d = sign_q;  is_load_d = is_load_q;
    off_d = off_q;  opcode_d = opcode_q;  rd_d = rd_q;  cnt_d = cnt_q;
    req_valid_d = req_valid_q;  we_d = we_q;  addr_d = addr_q;  be_d = be_q;
    wdata_d = wdata_q;  wb_rd_d = wb_rd_q;  wb_opcode_d = wb_opcode_q;
    wb_data_d = wb_data_q;
    wb_valid_d = 1'b0;  done_d = 1'b0;  align_err_d = 1'b0;  bus_err_d = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (issue_valid && op_now.valid) begin
          if (misaligned) begin
            align_err_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d     = ST_REQ;
            size_d      = op_now.size;
            sign_d      = op_now.sign_ext;
            is_load_d   = op_now.is_load;
            off_d       = ea_now[2:0];
            opcode_d    = opcode;
            rd_d        = rd;
            req_valid_d = 1'b1;
            we_d        = ~op_now.is_load;
            addr_d      = {ea_now[63:3], 3'b000};
            be_d        = al_be;
            wdata_d     = op_now.is_load ? 64'd0 : al_store;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving on the final allowed cycle still wins over timeout
        if (mem_rsp_valid) begin
          cnt_d = '0;
          if (is_load_q) begin
            wb_data_d   = al_load;
            wb_rd_d     = rd_q;
            wb_opcode_d = opcode_q;
            wb_valid_d  = 1'b1;
            done_d      = 1'b1;
            state_d     = ST_WB;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          cnt_d     = '0;
          bus_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;  size_q <= SZ_BYTE;  sign_q <= 1'b0;  is_load_q <= 1'b0;
      off_q <= '0;  opcode_q <= '0;  rd_q <= '0;  cnt_q <= '0;
      req_valid_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  be_q <= '0;  wdata_q <= '0;
      wb_valid_q <= 1'b0;  done_q <= 1'b0;  align_err_q <= 1'b0;  bus_err_q <= 1'b0;
      wb_rd_q <= '0;  wb_opcode_q <= '0;  wb_data_q <= '0;
    end else begin
      state_q <= state_d;  size_q <= size_d;  sign_q <= sign_d;  is_load_q <= is_load_d;
      off_q <= off_d;  opcode_q <= opcode_d;  rd_q <= rd_d;  cnt_q <= cnt_d;
      req_valid_q <= req_valid_d;  we_q <= we_d;  addr_q <= addr_d;  be_q <= be_d;
      wdata_q <= wdata_d;
      wb_valid_q <= wb_valid_d;  done_q <= done_d;  align_err_q <= align_err_d;
      bus_err_q <= bus_err_d;
      wb_rd_q <= wb_rd_d;  wb_opcode_q <= wb_opcode_d;  wb_data_q <= wb_data_d;
    end
  end

  assign issue_ready   = (state_q == ST_IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_opcode     = wb_opcode_q;
  assign wb_data       = wb_data_q;
  assign done          = done_q;
  assign align_err     = align_err_q;
  assign bus_err       = bus_err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage between the register read port and the register file write port of the uPower datapath.
- Takes the base register value, the store data and the D-form displacement, and computes the effective address.
- Runs one data-memory transaction over a valid/ready request and response-valid handshake.
- For loads, returns a zero- or sign-extended 64-bit writeback value with destination index and opcode, ready for the register file write path.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before bus_err; counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
issue_valid  input  1  instruction presented
issue_ready  output  1  unit can accept (high only in IDLE)
opcode  input  6  primary opcode
rd  input  5  load target / store source register index
ra_is_zero  input  1  RA field == 0 (base treated as 0)
ra_data  input  64  base register value (ReadData1)
rs_data  input  64  store data (ReadData2)
disp  input  16  D displacement, sign-extended to 64
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  1 = store
mem_addr  output  64  effective address, aligned down to 8 bytes
mem_be  output  8  byte enables, lane i = addr byte i (little-endian lanes)
mem_wdata  output  64  store data shifted into lanes
mem_rsp_valid  input  1  load data / store ack valid
mem_rdata  input  64  load data
wb_valid  output  1  one-cycle pulse, load result valid
wb_rd  output  5  writeback index
wb_opcode  output  6  opcode of completing load
wb_data  output  64  extended load value
done  output  1  one-cycle pulse at completion of any instruction, including error completions
align_err  output  1  one-cycle pulse, misaligned access rejected
bus_err  output  1  one-cycle pulse, response timeout

Behaviour:
- Opcodes:
  - Loads: 34 lbz (1B, zero-ext), 40 lhz (2B, zero), 42 lha (2B, sign), 32 lwz (4B, zero), 48 ld (8B).
  - Stores: 38 stb, 44 sth, 36 stw, 52 std.
  - Any other opcode with issue_valid in IDLE is ignored; issue_ready stays 1.
- EA = (ra_is_zero ? 0 : ra_data) + sext(disp), modulo 2^64; latched at accept.
- FSM states IDLE, REQ, WAIT, WB.
  - IDLE: issue_ready=1. On a valid load/store with an aligned EA, latch EA, size, opcode, rd and rs_data, then go to REQ.
  - IDLE, misaligned EA: pulse align_err and done next cycle, stay IDLE, no memory request. Misaligned means EA mod size != 0.
  - REQ: mem_req_valid=1, all request fields stable until mem_req_ready. Handshake completes in the cycle mem_req_ready=1, then go to WAIT.
  - WAIT: timeout counter increments each cycle. On mem_rsp_valid:
    - Load: register the extended data and go to WB.
    - Store: pulse done and go to IDLE.
  - WAIT timeout: counter reaching TIMEOUT_CYCLES pulses bus_err and done, then go to IDLE with no writeback.
  - WB: wb_valid=1 and done=1 for exactly one cycle, then IDLE.
- A response in the same cycle as the counter reaching its limit counts as success.
- mem_rsp_valid outside WAIT is ignored.
- Load extract: take bytes from lane EA[2:0] upward; zero- or sign-extend per opcode. Sign bit is bit 15 of the extracted value for lha.
- Store placement:
  - mem_be = size mask << EA[2:0].
  - mem_wdata = low bytes of rs_data shifted by 8*EA[2:0].
  - Unused lanes are 0.
- Latency with mem_req_ready=1 and response one cycle later: accept at T, request at T+1, response at T+2, wb_valid at T+3.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE.
  - All pulses and mem_req_valid clear to 0; wb_data, wb_rd, wb_opcode, mem_* clear to 0; counter clears.
  - No writeback for an in-flight load.

Decomposition:
- Shared package lsu_pkg holds:
  - Opcode constants (OP_LBZ=34, OP_LHZ=40, OP_LHA=42, OP_LWZ=32, OP_LD=48, OP_STB=38, OP_STH=44, OP_STW=36, OP_STD=52).
  - State enum.
  - Size encoding (1/2/4/8).
- One sub-module, lsu_align: purely combinational lane shift and extend. It serves both load extraction and store placement and byte-enable generation.

Test Plan:
- lbz, ra_data=0x1000, disp=0x0003, mem_rdata=0x0000_0000_AB00_0000 (immediate ready, response next cycle) -> mem_addr=0x1000, mem_be=0x08, wb_data=0xAB, wb_valid at T+3.
- lha, EA=0x2006, mem_rdata=0x8001_0000_0000_0000 -> mem_be=0xC0, wb_data=0xFFFF_FFFF_FFFF_8001; repeat with lhz -> 0x8001.
- stw, ra_is_zero=1, disp=0x0004, rs_data=0x1122_3344_5566_7788 -> mem_we=1, mem_be=0xF0, mem_wdata=0x5566_7788_0000_0000, done, no wb_valid.
- lwz with EA=0x1002 -> align_err and done pulse, mem_req_valid stays 0.
- ld with mem_req_ready held low 5 cycles -> request fields stable throughout; no mem_rsp_valid for TIMEOUT_CYCLES -> bus_err, return to IDLE.
- Assert rst during WAIT of an ld -> all outputs 0 immediately, IDLE. A late mem_rsp_valid after reset produces no wb_valid.
